// File: rtl/add_multicycle.sv
// add_multicycle: chunk-serial adder/subtractor with a start/done handshake.
// Handles CHUNK_WIDTH bits per cycle, keeping the ripple carry in a register
// between chunks. Rd and the flags change only when an operation completes.
module add_multicycle #(
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  Sub,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  ready,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] Rd,
  output logic                  Cout,
  output logic                  Overflow,
  output logic                  Zero
);

  localparam int NUM_CHUNKS = (CHUNK_WIDTH > 0) ? (DATA_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH : 1;
  localparam int PAD_WIDTH  = NUM_CHUNKS * CHUNK_WIDTH;
  localparam int CNT_WIDTH  = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_CHUNK = CNT_WIDTH'(NUM_CHUNKS - 1);

  // Reject illegal widths when the design is elaborated.
  if (DATA_WIDTH < 1) begin : gBadDataWidth
    $error("add_multicycle: DATA_WIDTH must be >= 1");
  end
  if (CHUNK_WIDTH < 1 || CHUNK_WIDTH > DATA_WIDTH) begin : gBadChunkWidth
    $error("add_multicycle: CHUNK_WIDTH must be in 1..DATA_WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } stateT;

  stateT state;
  stateT nextState;

  // Operands are right-shifted one chunk per cycle so the active chunk is
  // always in the low bits; the sum is assembled from the top downwards.
  logic [PAD_WIDTH-1:0]   aReg;
  logic [PAD_WIDTH-1:0]   bReg;
  logic [PAD_WIDTH-1:0]   sumReg;
  logic                   carryReg;
  logic [CNT_WIDTH-1:0]   chunkCnt;
  logic                   aMsb;
  logic                   bMsb;

  logic [DATA_WIDTH-1:0]  bSel;
  logic [CHUNK_WIDTH:0]   chunkSum;
  logic [PAD_WIDTH-1:0]   sumShifted;
  logic [PAD_WIDTH:0]     fullSum;
  logic                   lastChunk;
  logic                   accept;

  assign accept    = (state == S_IDLE) && start;
  assign lastChunk = (chunkCnt == LAST_CHUNK);
  // Subtraction is A + ~B + 1; the +1 enters as the initial carry.
  assign bSel      = Sub ? ~SrcB : SrcB;

  // One chunk of the ripple addition plus the sum register as it will look
  // after this cycle; on the last chunk that is the complete padded sum.
  always_comb begin
    chunkSum   = {1'b0, aReg[CHUNK_WIDTH-1:0]}
               + {1'b0, bReg[CHUNK_WIDTH-1:0]}
               + {{CHUNK_WIDTH{1'b0}}, carryReg};
    sumShifted = (sumReg >> CHUNK_WIDTH)
               | (PAD_WIDTH'(chunkSum[CHUNK_WIDTH-1:0]) << (PAD_WIDTH - CHUNK_WIDTH));
    // With an exact fit the top bit is the final carry; otherwise the carry
    // has already rippled into padded bit DATA_WIDTH of the sum.
    fullSum    = {chunkSum[CHUNK_WIDTH], sumShifted};
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic: IDLE -> RUN -> DONE -> IDLE.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    nextState = state;
    case (state)
      S_IDLE:  if (start) nextState = S_RUN;
      S_RUN:   if (lastChunk) nextState = S_DONE;
      S_DONE:  nextState = S_IDLE;
      default: nextState = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    ready = 1'b0;
    done  = 1'b0;
    case (state)
      S_IDLE:  ready = 1'b1;
      S_DONE:  done  = 1'b1;
      default: ;
    endcase
  end

  // Datapath: capture operands on accept, add one chunk per RUN cycle, and
  // publish Rd and flags only on the final chunk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aReg     <= '0;
      bReg     <= '0;
      sumReg   <= '0;
      carryReg <= 1'b0;
      chunkCnt <= '0;
      aMsb     <= 1'b0;
      bMsb     <= 1'b0;
      Rd       <= '0;
      Cout     <= 1'b0;
      Overflow <= 1'b0;
      Zero     <= 1'b0;
    end else if (accept) begin
      aReg     <= PAD_WIDTH'(SrcA);
      bReg     <= PAD_WIDTH'(bSel);
      carryReg <= Sub;
      chunkCnt <= '0;
      aMsb     <= SrcA[DATA_WIDTH-1];
      bMsb     <= bSel[DATA_WIDTH-1];
    end else if (state == S_RUN) begin
      aReg     <= aReg >> CHUNK_WIDTH;
      bReg     <= bReg >> CHUNK_WIDTH;
      sumReg   <= sumShifted;
      carryReg <= chunkSum[CHUNK_WIDTH];
      chunkCnt <= chunkCnt + CNT_WIDTH'(1);
      if (lastChunk) begin
        Rd       <= fullSum[DATA_WIDTH-1:0];
        Cout     <= fullSum[DATA_WIDTH];
        Overflow <= (aMsb == bMsb) && (fullSum[DATA_WIDTH-1] != aMsb);
        Zero     <= (fullSum[DATA_WIDTH-1:0] == '0);
      end
    end
  end

endmodule
